// File: rtl/fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_stage : IF stage with miss wait, one-entry hold buffer and flush.   |
// | Optional HALT stop enabled by defining FETCH_HALT_EN.  Revision: 1.0      |
// +--------------------------------------------------------------------------+
module fetch_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] redirectPC,
  output logic [15:0] imemAddr,
  output logic        imemRd,
  input  logic [15:0] imemData,
  input  logic        imemDone,
  output logic [15:0] instruction,
  output logic [15:0] pcPlus2,
  output logic        instrValidD,
  output logic [15:0] pc,
  output logic        halted
);

  localparam logic [15:0] C_NOP = 16'h0800;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DROP  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pcp2_q, pcp2_d;
  logic        valid_q, valid_d;
  logic        holdv_q, holdv_d;
  logic [15:0] holdw_q, holdw_d;
  logic        w_cap;
  logic [15:0] w_cap_word;
  logic        w_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= 16'h0000;
      instr_q <= C_NOP;
      pcp2_q  <= 16'h0000;
      valid_q <= 1'b0;
      holdv_q <= 1'b0;
      holdw_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp2_q  <= pcp2_d;
      valid_q <= valid_d;
      holdv_q <= holdv_d;
      holdw_q <= holdw_d;
    end
  end

  always_comb begin
    w_rd = 1'b0;
    case (state_q)
      S_FETCH: w_rd = !stall && !flush && !holdv_q;
      S_WAIT:  w_rd = 1'b1;
      default: w_rd = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pcp2_d     = pcp2_q;
    valid_d    = valid_q;
    holdv_d    = holdv_q;
    holdw_d    = holdw_q;
    w_cap      = 1'b0;
    w_cap_word = imemData;

    if (flush) begin
      // A read still in flight must have its response swallowed in DROP.
      pc_d    = redirectPC;
      valid_d = 1'b0;
      instr_d = C_NOP;
      holdv_d = 1'b0;
      state_d = ((state_q == S_WAIT || state_q == S_DROP) && !imemDone) ? S_DROP : S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (!stall) begin
            if (holdv_q) begin
              w_cap      = 1'b1;
              w_cap_word = holdw_q;
              holdv_d    = 1'b0;
            end else if (imemDone) begin
              w_cap = 1'b1;
            end else begin
              state_d = S_WAIT;
              valid_d = 1'b0;
              instr_d = C_NOP;
            end
          end
        end
        S_WAIT: begin
          if (imemDone) begin
            state_d = S_FETCH;
            if (stall) begin
              holdv_d = 1'b1;
              holdw_d = imemData;
            end else begin
              w_cap = 1'b1;
            end
          end else if (!stall) begin
            valid_d = 1'b0;
            instr_d = C_NOP;
          end
        end
        S_DROP: begin
          if (imemDone) state_d = S_FETCH;
          if (!stall) begin
            valid_d = 1'b0;
            instr_d = C_NOP;
          end
        end
        default: begin
          if (!stall) begin
            valid_d = 1'b0;
            instr_d = C_NOP;
          end
        end
      endcase

      if (w_cap) begin
        instr_d = w_cap_word;
        pcp2_d  = pc_q + 16'd2;
        pc_d    = pc_q + 16'd2;
        valid_d = 1'b1;
`ifdef FETCH_HALT_EN
        if (w_cap_word[15:11] == 5'b00000) state_d = S_HALT;
`endif
      end
    end
  end

  assign imemAddr    = pc_q;
  assign imemRd      = w_rd;
  assign instruction = instr_q;
  assign pcPlus2     = pcp2_q;
  assign instrValidD = valid_q;
  assign pc          = pc_q;
`ifdef FETCH_HALT_EN
  assign halted = (state_q == S_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 stall  input  1  decode-side hazard stall; hold IF/ID outputs, issue no new fetch.
REQ-004 flush  input  1  taken branch/jump from execute; redirect PC, squash fetch in flight.
REQ-005 redirectPC  input  16  target PC, valid when flush=1.
REQ-006 imemAddr  output  16  instruction memory address, equals pc.
REQ-007 imemRd  output  1  instruction memory read request.
REQ-008 imemData  input  16  instruction word, valid when imemDone=1.
REQ-009 imemDone  input  1  read complete this cycle; may assert in the request cycle (hit) or later.
REQ-010 instruction  output  16  registered IF/ID instruction, feeds decode.
REQ-011 pcPlus2  output  16  registered PC+2 of the held instruction.
REQ-012 instrValidD  output  1  held instruction is real, not a bubble.
REQ-013 pc  output  16  current fetch PC.
REQ-014 halted  output  1  fetch stopped on HALT.

Function
REQ-015 States: FETCH, WAIT, DROP, HALT.
REQ-016 FETCH: imemRd=1 iff stall=0 and flush=0; imemAddr=pc at all times.
REQ-017 FETCH, request with imemDone=1: capture instruction<=imemData, pcPlus2<=pc+2, instrValidD<=1, pc<=pc+2; stay in FETCH.
REQ-018 FETCH, request with imemDone=0: go to WAIT; imemRd stays 1 in WAIT; pc held.
REQ-019 WAIT, imemDone=1 with stall=0: capture as in REQ-017; go to FETCH.
REQ-020 WAIT, imemDone=1 with stall=1: store word in a one-entry hold buffer; go to FETCH; buffered word loads into IF/ID on the first cycle stall=0, and no new request issues that cycle.
REQ-021 stall=1 with no capture pending: instruction, pcPlus2, instrValidD, pc unchanged.
REQ-022 flush=1 in any state: pc<=redirectPC; instrValidD<=0; instruction<=16'h0800 (NOP); hold buffer cleared; state<=DROP if a read is outstanding (WAIT), else FETCH.
REQ-023 flush overrides stall and a same-cycle imemDone; that response is discarded.
REQ-024 DROP: imemRd=0; next imemDone discarded; then FETCH.
REQ-025 Not stalled and no capture this cycle (miss outstanding): instrValidD<=0, instruction<=16'h0800 (bubble).
REQ-026 PC arithmetic 16-bit modulo: pc 16'hFFFE increments to 16'h0000.

Reset
REQ-027 On rst=1 at a clock edge: pc=0, state=FETCH, instruction=16'h0800, pcPlus2=0, instrValidD=0, halted=0, hold buffer empty.
REQ-028 rst overrides flush, stall, imemDone; a response outstanding at reset is ignored (memory resets on the same rst).

Configuration
REQ-029 Macro FETCH_HALT_EN defined: capturing a word with [15:11]=5'b00000 enters HALT; imemRd=0, pc frozen at halt address+2, halted=1; only flush or rst leaves HALT.
REQ-030 FETCH_HALT_EN undefined: HALT state absent, halted tied 0, HALT words fetched like any other instruction.

Verification
REQ-031 Reset, then single-cycle hits of 16'hC001 at 0 and 16'hC102 at 2 -> instruction 16'hC001/pcPlus2=2, then 16'hC102/pcPlus2=4, instrValidD=1, pc=4.
REQ-032 Miss at pc=6, imemDone 3 cycles later with 16'hD000 -> imemRd high throughout, instrValidD=0 for 3 cycles, then instruction=16'hD000, pc=8.
REQ-033 stall=1 in WAIT, imemDone with 16'hA5A5, stall released 2 cycles later -> outputs unchanged during stall, 16'hA5A5 presented the cycle after release, no request that cycle.
REQ-034 flush=1, redirectPC=16'h0040 during WAIT -> instrValidD=0, next imemDone discarded, following fetch address 16'h0040.
REQ-035 FETCH_HALT_EN defined, HALT word 16'h0000 at pc=10 -> halted=1, pc=12, imemRd=0; then flush to 16'h0020 -> halted=0, fetch resumes at 16'h0020.
REQ-036 pc=16'hFFFE hit -> pcPlus2=0, pc=0; rst asserted mid-WAIT -> all REQ-027 values next cycle.
